// File: rtl/sine_pkg.sv
// Shared definitions for the sine Taylor-series engine.
//   state_t   : controller states
//   Q_W       : Q8.8 word width
//   FRAC_BITS : fractional bits of the Q8.8 format
//   SEL_W     : width of the coefficient-table select
//   MAX_TERMS : largest supported number of series terms
package sine_pkg;

  localparam int Q_W       = 16;
  localparam int FRAC_BITS = 8;
  localparam int SEL_W     = 3;
  localparam int MAX_TERMS = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SQUARE  = 3'd1,
    MUL_X2  = 3'd2,
    MUL_DIV = 3'd3,
    ACCUM   = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/q88_mul.sv
// Combinational signed Q8.8 multiply.
//   a, b : signed Q8.8 operands
//   p    : signed Q8.8 product, bits [23:8] of the full 32-bit product
// Taking the middle slice of a two's-complement product is a floor
// (toward negative infinity) truncation; no rounding or saturation.
module q88_mul
  import sine_pkg::*;
(
  input  logic signed [Q_W-1:0] a,
  input  logic signed [Q_W-1:0] b,
  output logic signed [Q_W-1:0] p
);

  logic signed [2*Q_W-1:0] prod;
  logic [FRAC_BITS-1:0]    unused_lo;
  logic [FRAC_BITS-1:0]    unused_hi;

  assign prod = a * b;
  assign {unused_hi, p, unused_lo} = prod;

endmodule

// File: rtl/sine_taylor_engine.sv
// Sequential Q8.8 sine evaluator using an alternating Taylor series.
//   clk, rst : clock, synchronous active-high reset
//   start    : request, accepted only in IDLE
//   x        : signed Q8.8 angle (valid -2.0..+2.0)
//   sel      : coefficient-table select (equals iteration index k)
//   div      : Q8.8 coefficient 1/((2k+2)(2k+3)) from the external table
//   busy     : high in every state except IDLE
//   done     : one-cycle pulse, result valid from this cycle
//   result   : signed Q8.8 sine, held until the next accepted start
//
// state   | meaning
// IDLE    | waiting for start; latches x into xr, acc and term
// SQUARE  | x2 = xr * xr
// MUL_X2  | t = term * x2
// MUL_DIV | term = t * coef[k]
// ACCUM   | acc -/+ term (even/odd k); last k updates result
// DONE    | done pulse, back to IDLE
module sine_taylor_engine
  import sine_pkg::*;
#(
  parameter int N_TERMS = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [Q_W-1:0]   x,
  output logic [SEL_W-1:0] sel,
  input  logic [Q_W-1:0]   div,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   result
);

  localparam logic [SEL_W-1:0] LAST_K = SEL_W'(N_TERMS - 2);

  state_t                 state;
  logic signed [Q_W-1:0]  xr;
  logic signed [Q_W-1:0]  x2;
  logic signed [Q_W-1:0]  term;
  logic signed [Q_W-1:0]  t;
  logic signed [Q_W-1:0]  acc;
  logic [SEL_W-1:0]       k;

  logic signed [Q_W-1:0]  mul_a;
  logic signed [Q_W-1:0]  mul_b;
  logic signed [Q_W-1:0]  mul_p;
  logic signed [Q_W-1:0]  acc_nxt;

  // One multiplier shared across the three multiply states.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      SQUARE:  begin mul_a = xr;   mul_b = xr;           end
      MUL_X2:  begin mul_a = term; mul_b = x2;           end
      MUL_DIV: begin mul_a = t;    mul_b = signed'(div); end
      default: begin mul_a = '0;   mul_b = '0;           end
    endcase
  end

  q88_mul u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  // k=0 is the x^3 term, which is subtracted; signs alternate from there.
  assign acc_nxt = k[0] ? (acc + term) : (acc - term);
  assign sel     = k;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      xr     <= '0;
      x2     <= '0;
      term   <= '0;
      t      <= '0;
      acc    <= '0;
      k      <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            xr    <= signed'(x);
            acc   <= signed'(x);
            term  <= signed'(x);
            k     <= '0;
            busy  <= 1'b1;
            state <= SQUARE;
          end
        end
        SQUARE: begin
          x2    <= mul_p;
          state <= MUL_X2;
        end
        MUL_X2: begin
          t     <= mul_p;
          state <= MUL_DIV;
        end
        MUL_DIV: begin
          term  <= mul_p;
          state <= ACCUM;
        end
        ACCUM: begin
          acc <= acc_nxt;
          if (k == LAST_K) begin
            result <= acc_nxt;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            k     <= k + SEL_W'(1);
            state <= MUL_X2;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sine_taylor_engine.sv
module tb_sine_taylor_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start2;
  logic [15:0] x;
  logic [2:0]  sel, sel2;
  logic [15:0] div, div2;
  logic        busy, busy2, done, done2;
  logic [15:0] result, result2;

  always #5 clk = ~clk;

  // Reciprocal table, floor-truncated to Q8.8: 256/6, 256/20, 256/42, 256/72, 256/110.
  function automatic logic [15:0] coef(input logic [2:0] s);
    case (s)
      3'd0:    coef = 16'd42;
      3'd1:    coef = 16'd12;
      3'd2:    coef = 16'd6;
      3'd3:    coef = 16'd3;
      3'd4:    coef = 16'd2;
      default: coef = 16'h7FFF;
    endcase
  endfunction

  assign div  = coef(sel);
  assign div2 = coef(sel2);

  sine_taylor_engine #(.N_TERMS(6)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .sel(sel), .div(div),
    .busy(busy), .done(done), .result(result)
  );

  sine_taylor_engine #(.N_TERMS(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .x(x), .sel(sel2), .div(div2),
    .busy(busy2), .done(done2), .result(result2)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] res;
    int          stamp;
    bit          chkres;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] res;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every done pulse pops one expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        exp_t e;
        if (sbq.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          e = sbq.pop_front();
          if (e.chkres) chk("result", {16'd0, result}, {16'd0, e.res});
          chk("latency", cyc - e.stamp, 32'd17);
        end
      end
    end
  end

  task automatic do_start(input logic [15:0] xv, input logic [15:0] ev, input bit cr);
    @(negedge clk);
    x     = xv;
    start = 1'b1;
    sbq.push_back('{res: ev, stamp: cyc, chkres: cr});
    @(negedge clk);
    start = 1'b0;
    x     = 16'($urandom);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk(name, sbq.size(), 32'd0);
      sbq.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] prev;
    int          s;
    bit          got;
    int          n;

    vecs[0] = '{x: 16'h0100, res: 16'h00D7};
    vecs[1] = '{x: 16'hFF00, res: 16'hFF29};
    vecs[2] = '{x: 16'h0080, res: 16'h007B};
    vecs[3] = '{x: 16'h0200, res: 16'h00EA};
    vecs[4] = '{x: 16'hFE00, res: 16'hFF17};
    vecs[5] = '{x: 16'h0000, res: 16'h0000};

    rst = 1'b1; start = 1'b0; start2 = 1'b0; x = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_done",   {31'd0, done},   32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_sel",    {29'd0, sel},    32'd0);
    chk("rst_busy2",  {31'd0, busy2},  32'd0);
    rst = 1'b0;

    // Two-term build: single iteration, 5-cycle latency, sel stays 0.
    @(negedge clk);
    x = 16'h0100; start2 = 1'b1; s = cyc;
    @(negedge clk);
    start2 = 1'b0;
    got = 1'b0; n = 0;
    while (!got && n < 20) begin
      chk("n2_sel", {29'd0, sel2}, 32'd0);
      if (done2 === 1'b1) begin
        chk("n2_result",  {16'd0, result2}, 32'h00D6);
        chk("n2_latency", cyc - s, 32'd5);
        got = 1'b1;
      end else begin
        @(negedge clk);
        n++;
      end
    end
    chk("n2_done_seen", {31'd0, got}, 32'd1);

    prev = 16'h0000;
    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].x, vecs[i].res, 1'b1);
      chk("busy_after_start", {31'd0, busy}, 32'd1);
      repeat (15) @(negedge clk);
      chk("result_hold", {16'd0, result}, {16'd0, prev});
      wait_drain("vec_timeout");
      @(negedge clk);
      chk("busy_idle", {31'd0, busy}, 32'd0);
      prev = vecs[i].res;
    end

    // sel walks 0..4, three cycles each, starting at cycle 2.
    do_start(16'h0000, 16'h0000, 1'b1);
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      chk("sel_seq",  {29'd0, sel},  32'((c - 2) / 3));
      chk("busy_run", {31'd0, busy}, 32'd1);
    end
    wait_drain("sel_timeout");

    // Out-of-range angle: value unspecified but done must arrive on time.
    do_start(16'h4000, 16'h0000, 1'b0);
    wait_drain("oor_timeout");

    // Starts while busy and during DONE are ignored; the one after DONE is taken.
    @(negedge clk);
    x = 16'h0100; start = 1'b1;
    sbq.push_back('{res: 16'h00D7, stamp: cyc, chkres: 1'b1});
    for (int r = 1; r <= 18; r++) begin
      @(negedge clk);
      start = (r == 3 || r == 17 || r == 18);
      x     = (r == 18) ? 16'hFF00 : 16'($urandom);
      if (r == 18) sbq.push_back('{res: 16'hFF29, stamp: cyc, chkres: 1'b1});
    end
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore_timeout");
    repeat (5) @(negedge clk);

    // Mid-run reset aborts without a done pulse.
    @(negedge clk);
    x = 16'h0200; start = 1'b1;
    for (int r = 1; r <= 8; r++) begin
      @(negedge clk);
      start = 1'b0;
      if (r == 8) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",   {31'd0, busy},   32'd0);
    chk("abort_done",   {31'd0, done},   32'd0);
    chk("abort_result", {16'd0, result}, 32'd0);
    chk("abort_sel",    {29'd0, sel},    32'd0);
    repeat (25) @(negedge clk);
    do_start(16'h0100, 16'h00D7, 1'b1);
    wait_drain("post_reset_timeout");
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
